vscale_rs2_share_merger: RTL and testbench

//  Recombines the SHARES Boolean (XOR) shares of the rs2 operand into one merged word.
//  The merged word drives rs2_data_merged of the ALU source-B select stage.

---
 rtl/vscale_rs2_share_merger_if.sv | 25 ++
 rtl/vscale_rs2_share_merger.sv | 116 +++++++++++
 tb/tb_vscale_rs2_share_merger.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vscale_rs2_share_merger_if.sv
// Handshake bundle between the rs2 share producer, the share merger and the ALU source-B consumer.
interface vscale_rs2_share_merger_if #(
  parameter int DWIDTH = 32,
  parameter int SHARES = 2
);
  // A transfer happens on a rising clk edge where valid and ready are both high.
  // A source holds valid and its payload stable until that edge; kill overrides any transfer.
  logic                     in_valid;
  logic                     in_ready;
  logic [SHARES*DWIDTH-1:0] rs2_shares;
  logic                     kill;
  logic                     out_valid;
  logic                     out_ready;
  logic [DWIDTH-1:0]        rs2_data_merged;

  modport master (
    output in_valid, rs2_shares, kill, out_ready,
    input  in_ready, out_valid, rs2_data_merged
  );

  modport slave (
    input  in_valid, rs2_shares, kill, out_ready,
    output in_ready, out_valid, rs2_data_merged
  );
endinterface

// File: rtl/vscale_rs2_share_merger.sv
// Recombines XOR shares of rs2 into one word, folding in one share per cycle through a
// registered accumulator so no two shares ever meet in the same combinational cone.
module vscale_rs2_share_merger #(
  parameter int DWIDTH = 32,
  parameter int SHARES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  vscale_rs2_share_merger_if.slave bus,
  output logic [1:0]               dbg_state,
  output logic [SHARES*DWIDTH-1:0] dbg_shares
);
  localparam int IW = $clog2(SHARES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IW-1:0]     idx;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] share_q [SHARES];
  logic [DWIDTH-1:0] sel_share;
  logic              last_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next          = state;
    bus.in_ready        = 1'b0;
    bus.out_valid       = 1'b0;
    bus.rs2_data_merged = '0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (SHARES > 1) state_next = ACCUM;
          else            state_next = DONE;
        end
      end
      ACCUM: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        // acc is only exposed here so partial sums never reach the consumer
        bus.out_valid       = 1'b1;
        bus.rs2_data_merged = acc;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.kill) state_next = IDLE;
  end

  always_comb begin
    sel_share = '0;
    for (int i = 0; i < SHARES; i++) begin
      if (idx == IW'(i)) sel_share = share_q[i];
    end
    last_step = (idx == IW'(SHARES - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      idx <= '0;
      for (int i = 0; i < SHARES; i++) share_q[i] <= '0;
    end else if (bus.kill) begin
      acc <= '0;
      idx <= '0;
      for (int i = 0; i < SHARES; i++) share_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc <= bus.rs2_shares[DWIDTH-1:0];
            idx <= (SHARES > 1) ? IW'(1) : '0;
            for (int i = 0; i < SHARES; i++) share_q[i] <= bus.rs2_shares[i*DWIDTH +: DWIDTH];
            share_q[0] <= '0;
          end
        end
        ACCUM: begin
          // each share register is wiped right after it is folded in
          acc <= acc ^ sel_share;
          for (int i = 0; i < SHARES; i++) begin
            if (idx == IW'(i)) share_q[i] <= '0;
          end
          if (!last_step) idx <= idx + IW'(1);
        end
        DONE: begin
          if (bus.out_ready) begin
            acc <= '0;
            idx <= '0;
          end
        end
        default: begin
          acc <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  always_comb begin
    dbg_shares = '0;
    for (int i = 0; i < SHARES; i++) dbg_shares[i*DWIDTH +: DWIDTH] = share_q[i];
  end
endmodule

// File: tb/tb_vscale_rs2_share_merger.sv
// Directed bench for the rs2 share merger: one 2-share and one 3-share instance.
module tb_vscale_rs2_share_merger;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  logic [1:0]  st2;
  logic [1:0]  st3;
  logic [63:0] sh2;
  logic [95:0] sh3;

  vscale_rs2_share_merger_if #(.DWIDTH(32), .SHARES(2)) b2 ();
  vscale_rs2_share_merger_if #(.DWIDTH(32), .SHARES(3)) b3 ();

  vscale_rs2_share_merger #(.DWIDTH(32), .SHARES(2)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (b2),
    .dbg_state  (st2),
    .dbg_shares (sh2)
  );

  vscale_rs2_share_merger #(.DWIDTH(32), .SHARES(3)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (b3),
    .dbg_state  (st3),
    .dbg_shares (sh3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic rdy, input logic vld, input logic [31:0] dat);
    check({tag, ".in_ready"},  96'(b3.in_ready),        96'(rdy));
    check({tag, ".out_valid"}, 96'(b3.out_valid),       96'(vld));
    check({tag, ".merged"},    96'(b3.rs2_data_merged), 96'(dat));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n       = 1'b0;
    b2.in_valid   = 1'b1;
    b2.rs2_shares = 64'h1111_2222_3333_4444;
    b2.kill       = 1'b0;
    b2.out_ready  = 1'b0;
    b3.in_valid   = 1'b1;
    b3.rs2_shares = 96'h1111_2222_3333_4444_5555_6666;
    b3.kill       = 1'b0;
    b3.out_ready  = 1'b0;

    // reset held with in_valid high
    #2;
    check("rst2.in_ready",  96'(b2.in_ready),        96'(1));
    check("rst2.out_valid", 96'(b2.out_valid),       96'(0));
    check("rst2.merged",    96'(b2.rs2_data_merged), 96'(0));
    tick();
    tick();
    chk3("rst3", 1'b1, 1'b0, 32'h0);
    check("rst3.state",  96'(st3), 96'(0));
    check("rst3.shares", sh3,      96'(0));
    b2.in_valid = 1'b0;
    b3.in_valid = 1'b0;
    reset_n     = 1'b1;
    tick();

    // SHARES=2: two-cycle latency
    b2.rs2_shares = {32'h5A5A_F0F0, 32'h5A5A_0F0F};
    b2.in_valid   = 1'b1;
    tick();
    b2.in_valid = 1'b0;
    check("s2.acc.out_valid", 96'(b2.out_valid),       96'(0));
    check("s2.acc.in_ready",  96'(b2.in_ready),        96'(0));
    check("s2.acc.merged",    96'(b2.rs2_data_merged), 96'(0));
    check("s2.acc.shares",    96'(sh2),                96'({32'h5A5A_F0F0, 32'h0}));
    tick();
    check("s2.done.out_valid", 96'(b2.out_valid),       96'(1));
    check("s2.done.merged",    96'(b2.rs2_data_merged), 96'(32'h0000_FFFF));
    check("s2.done.shares",    96'(sh2),                96'(0));
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;
    check("s2.idle.in_ready",  96'(b2.in_ready),  96'(1));
    check("s2.idle.out_valid", 96'(b2.out_valid), 96'(0));

    // SHARES=3: three-cycle latency, in_ready low until back in IDLE
    b3.rs2_shares = {32'h4, 32'h2, 32'h1};
    b3.in_valid   = 1'b1;
    b3.out_ready  = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    chk3("s3.c1", 1'b0, 1'b0, 32'h0);
    check("s3.c1.shares", sh3, {32'h4, 32'h2, 32'h0});
    tick();
    chk3("s3.c2", 1'b0, 1'b0, 32'h0);
    check("s3.c2.shares", sh3, {32'h4, 32'h0, 32'h0});
    tick();
    chk3("s3.done", 1'b0, 1'b1, 32'h7);
    check("s3.done.shares", sh3, 96'(0));
    tick();
    chk3("s3.idle", 1'b1, 1'b0, 32'h0);

    // backpressure in DONE
    b3.out_ready  = 1'b0;
    b3.rs2_shares = {32'hFFFF_0000, 32'h0F0F_0F0F, 32'hA5A5_A5A5};
    b3.in_valid   = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk3("bp.hold", 1'b0, 1'b1, 32'h5555_AAAA);
      tick();
    end
    chk3("bp.xfer", 1'b0, 1'b1, 32'h5555_AAAA);
    b3.out_ready = 1'b1;
    tick();
    b3.out_ready = 1'b0;
    chk3("bp.idle", 1'b1, 1'b0, 32'h0);

    // kill one cycle after accept
    b3.rs2_shares = {32'h0F0F_0F0F, 32'h9ABC_DEF0, 32'h1234_5678};
    b3.in_valid   = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    b3.kill     = 1'b1;
    tick();
    b3.kill = 1'b0;
    chk3("kill.idle", 1'b1, 1'b0, 32'h0);
    check("kill.state",  96'(st3), 96'(0));
    check("kill.shares", sh3,      96'(0));
    for (int k = 0; k < 3; k++) begin
      check("kill.no_valid", 96'(b3.out_valid), 96'(0));
      tick();
    end

    // kill in IDLE with in_valid high: nothing captured
    b3.in_valid = 1'b1;
    b3.kill     = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    b3.kill     = 1'b0;
    check("kill_idle.state",  96'(st3), 96'(0));
    check("kill_idle.shares", sh3,      96'(0));

    // next operand after a kill
    b3.rs2_shares = {32'h0, 32'h2152_BEEF, 32'hFFFF_0000};
    b3.in_valid   = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    tick();
    tick();
    chk3("post_kill", 1'b0, 1'b1, 32'hDEAD_BEEF);

    // kill in DONE while out_ready is high
    b3.out_ready = 1'b1;
    b3.kill      = 1'b1;
    tick();
    b3.out_ready = 1'b0;
    b3.kill      = 1'b0;
    chk3("kill_done", 1'b1, 1'b0, 32'h0);
    check("kill_done.state", 96'(st3), 96'(0));

    // async reset between clock edges in the middle of ACCUM
    b3.rs2_shares = {32'hCAFE_0001, 32'h0BAD_0002, 32'h1357_0003};
    b3.in_valid   = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    check("areset.pre.state", 96'(st3), 96'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk3("areset", 1'b1, 1'b0, 32'h0);
    check("areset.state",  96'(st3), 96'(0));
    check("areset.shares", sh3,      96'(0));
    tick();
    reset_n = 1'b1;
    tick();
    chk3("areset.after", 1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
